dmem_responder: RTL and testbench

Data-memory responder serving the CPU's load/store port in the MEM stage.
- Accepts one request at a time over a valid/ready request channel.
- Performs RV64 byte, half, word or double accesses on a doubleword-organised array.
- Returns load data, sign- or zero-extended per funct3, over a valid/ready response channel after a fixed latency.
- Replaces the combinational data cache so the pipeline can be exercised against a multi-cycle memory.

---
 rtl/dmem_responder.sv | 204 ++++++++++++++++++++
 tb/tb_dmem_responder.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM-stage load/store port: single outstanding request,
// fixed-latency response, RV64 byte/half/word/double accesses on a doubleword array.
module dmem_responder #(
    parameter int DEPTH   = 128,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [63:0] req_addr,
    input  logic [2:0]  req_size,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [60:0] DEPTH_L = 61'(DEPTH);
    localparam logic [3:0]  LAT_M1  = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [3:0]  cnt_r;
    logic [3:0]  cnt_next_s;
    logic        req_ready_r;
    logic        rsp_valid_r;
    logic [63:0] rsp_rdata_r;
    logic        rsp_err_r;

    logic [63:0] mem_r [DEPTH];

    logic [60:0]   index_s;
    logic [2:0]    offset_s;
    logic [IW-1:0] row_s;
    logic          in_range_s;
    logic          illegal_s;
    logic          misaligned_s;
    logic          err_s;
    logic          accept_s;
    logic          wr_en_s;
    logic [63:0]   rd_word_s;
    logic [63:0]   rd_shift_s;
    logic [63:0]   load_val_s;
    logic [63:0]   wmask_s;
    logic [63:0]   wdata_sh_s;

    function automatic logic [7:0] size_byte_mask(input logic [1:0] sz, input logic [2:0] off);
        logic [7:0] base;
        case (sz)
            2'b00:   base = 8'h01;
            2'b01:   base = 8'h03;
            2'b10:   base = 8'h0F;
            2'b11:   base = 8'hFF;
            default: base = 8'h00;
        endcase
        return base << off;
    endfunction

    function automatic logic [63:0] expand_mask(input logic [7:0] bm);
        logic [63:0] m;
        m = 64'd0;
        for (int i = 0; i < 8; i++) begin
            m[8*i +: 8] = {8{bm[i]}};
        end
        return m;
    endfunction

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;

    // Address split, fault detection and acceptance
    always_comb begin
        index_s    = req_addr[63:3];
        offset_s   = req_addr[2:0];
        row_s      = index_s[IW-1:0];
        in_range_s = (index_s < DEPTH_L);
        illegal_s  = req_we ? req_size[2] : (req_size == 3'b111);
        case (req_size[1:0])
            2'b00:   misaligned_s = 1'b0;
            2'b01:   misaligned_s = offset_s[0];
            2'b10:   misaligned_s = (offset_s[1:0] != 2'b00);
            2'b11:   misaligned_s = (offset_s != 3'b000);
            default: misaligned_s = 1'b1;
        endcase
        err_s    = illegal_s || misaligned_s || !in_range_s;
        accept_s = (state_r == ST_IDLE) && req_ready_r && req_valid;
        wr_en_s  = accept_s && req_we && !err_s;
    end

    // Read path: fetch the doubleword, right-align the addressed bytes, extend per funct3
    always_comb begin
        if (in_range_s) begin
            rd_word_s = mem_r[row_s];
        end else begin
            rd_word_s = 64'd0;
        end
        rd_shift_s = rd_word_s >> {offset_s, 3'b000};
        case (req_size)
            3'b000:  load_val_s = {{56{rd_shift_s[7]}},  rd_shift_s[7:0]};
            3'b001:  load_val_s = {{48{rd_shift_s[15]}}, rd_shift_s[15:0]};
            3'b010:  load_val_s = {{32{rd_shift_s[31]}}, rd_shift_s[31:0]};
            3'b011:  load_val_s = rd_shift_s;
            3'b100:  load_val_s = {56'd0, rd_shift_s[7:0]};
            3'b101:  load_val_s = {48'd0, rd_shift_s[15:0]};
            3'b110:  load_val_s = {32'd0, rd_shift_s[31:0]};
            default: load_val_s = 64'd0;
        endcase
        wmask_s    = expand_mask(size_byte_mask(req_size[1:0], offset_s));
        wdata_sh_s = req_wdata << {offset_s, 3'b000};
    end

    // Array storage: cleared on reset, byte-masked store commit at acceptance
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 64'd0;
            end
        end else if (wr_en_s) begin
            mem_r[row_s] <= (rd_word_s & ~wmask_s) | (wdata_sh_s & wmask_s);
        end
    end

    // Next-state and latency counter logic
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (LATENCY > 1) begin
                        state_next_s = ST_BUSY;
                        cnt_next_s   = LAT_M1;
                    end else begin
                        state_next_s = ST_RESP;
                        cnt_next_s   = 4'd0;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                cnt_next_s = cnt_r - 4'd1;
                if (cnt_r <= 4'd1) begin
                    state_next_s = ST_RESP;
                end else begin
                    state_next_s = ST_BUSY;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RESP;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = 4'd0;
            end
        endcase
    end

    // State, counter and handshake flags; ready/valid follow the next state so they are registered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 4'd0;
            req_ready_r <= 1'b0;
            rsp_valid_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            cnt_r       <= cnt_next_s;
            req_ready_r <= (state_next_s == ST_IDLE);
            rsp_valid_r <= (state_next_s == ST_RESP);
        end
    end

    // Response payload: captured at acceptance, held through backpressure, cleared after handshake
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_rdata_r <= 64'd0;
            rsp_err_r   <= 1'b0;
        end else if (accept_s) begin
            rsp_rdata_r <= (req_we || err_s) ? 64'd0 : load_val_s;
            rsp_err_r   <= err_s;
        end else if ((state_r == ST_RESP) && rsp_ready) begin
            rsp_rdata_r <= 64'd0;
            rsp_err_r   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three builds (LATENCY 2, 3, 1) share clock, reset and
// request fields; only the selected instance sees req_valid and the driven rsp_ready.
module tb_dmem_responder;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [63:0] req_addr;
    logic [2:0]  req_size;
    logic [63:0] req_wdata;
    logic        rsp_ready_drv;
    int          sel;

    logic        rv_in  [3];
    logic        rr_in  [3];
    logic        rq_rdy [3];
    logic        rsp_v  [3];
    logic [63:0] rsp_d  [3];
    logic        rsp_e  [3];

    int n_checks;
    int n_pass;

    assign rv_in[0] = (sel == 0) && req_valid;
    assign rv_in[1] = (sel == 1) && req_valid;
    assign rv_in[2] = (sel == 2) && req_valid;
    assign rr_in[0] = (sel == 0) ? rsp_ready_drv : 1'b1;
    assign rr_in[1] = (sel == 1) ? rsp_ready_drv : 1'b1;
    assign rr_in[2] = (sel == 2) ? rsp_ready_drv : 1'b1;

    dmem_responder #(.DEPTH(128), .LATENCY(2)) dut_l2 (
        .clk(clk), .rst(rst), .req_valid(rv_in[0]), .req_ready(rq_rdy[0]), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata), .rsp_valid(rsp_v[0]),
        .rsp_ready(rr_in[0]), .rsp_rdata(rsp_d[0]), .rsp_err(rsp_e[0])
    );

    dmem_responder #(.DEPTH(128), .LATENCY(3)) dut_l3 (
        .clk(clk), .rst(rst), .req_valid(rv_in[1]), .req_ready(rq_rdy[1]), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata), .rsp_valid(rsp_v[1]),
        .rsp_ready(rr_in[1]), .rsp_rdata(rsp_d[1]), .rsp_err(rsp_e[1])
    );

    dmem_responder #(.DEPTH(128), .LATENCY(1)) dut_l1 (
        .clk(clk), .rst(rst), .req_valid(rv_in[2]), .req_ready(rq_rdy[2]), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata), .rsp_valid(rsp_v[2]),
        .rsp_ready(rr_in[2]), .rsp_rdata(rsp_d[2]), .rsp_err(rsp_e[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request to the selected instance; lat = negedges from acceptance to rsp_valid
    task automatic do_req(input logic we, input logic [63:0] addr, input logic [2:0] size,
                          input logic [63:0] wdata, output logic [63:0] rdata,
                          output logic err, output int lat);
        bit ok;
        rdata = 64'd0;
        err   = 1'b0;
        lat   = 0;
        ok    = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rq_rdy[sel]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            chk("ready_timeout", {63'd0, ok}, 64'd1);
            return;
        end
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_size  = size;
        req_wdata = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        ok = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (rsp_v[sel]) begin
                lat = i;
                ok  = 1'b1;
                break;
            end
        end
        if (!ok) begin
            chk("rsp_timeout", {63'd0, ok}, 64'd1);
            return;
        end
        rdata = rsp_d[sel];
        err   = rsp_e[sel];
        @(posedge clk);
        #1;
    endtask

    task automatic req_check(input string tag, input logic we, input logic [63:0] addr,
                             input logic [2:0] size, input logic [63:0] wdata,
                             input logic [63:0] exp_rdata, input logic exp_err, input int exp_lat);
        logic [63:0] rd;
        logic        er;
        int          lt;
        do_req(we, addr, size, wdata, rd, er, lt);
        chk({tag, "_rdata"}, rd, exp_rdata);
        chk({tag, "_err"}, {63'd0, er}, {63'd0, exp_err});
        chk({tag, "_lat"}, 64'(lt), 64'(exp_lat));
    endtask

    initial begin
        logic [63:0] exp_d;
        bit          ok;
        n_checks      = 0;
        n_pass        = 0;
        sel           = 0;
        rst           = 1'b0;
        req_valid     = 1'b0;
        req_we        = 1'b0;
        req_addr      = 64'd0;
        req_size      = 3'd0;
        req_wdata     = 64'd0;
        rsp_ready_drv = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_req_ready", {63'd0, rq_rdy[0]}, 64'd0);
        chk("rst_rsp_valid", {63'd0, rsp_v[0]}, 64'd0);
        chk("rst_rsp_rdata", rsp_d[0], 64'd0);
        chk("rst_rsp_err", {63'd0, rsp_e[0]}, 64'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {63'd0, rq_rdy[0]}, 64'd1);

        // Doubleword store/load and sub-word accesses, LATENCY=2
        req_check("sd_10", 1'b1, 64'h10, 3'b011, 64'h1122334455667788, 64'd0, 1'b0, 2);
        req_check("ld_10", 1'b0, 64'h10, 3'b011, 64'd0, 64'h1122334455667788, 1'b0, 2);
        req_check("sb_15", 1'b1, 64'h15, 3'b000, 64'h00000000000000FF, 64'd0, 1'b0, 2);
        req_check("lb_15", 1'b0, 64'h15, 3'b000, 64'd0, 64'hFFFFFFFFFFFFFFFF, 1'b0, 2);
        req_check("lbu_15", 1'b0, 64'h15, 3'b100, 64'd0, 64'h00000000000000FF, 1'b0, 2);
        req_check("ld_10b", 1'b0, 64'h10, 3'b011, 64'd0, 64'h1122FF4455667788, 1'b0, 2);
        req_check("sh_08", 1'b1, 64'h08, 3'b001, 64'hFFFFFFFFFFFF8001, 64'd0, 1'b0, 2);
        req_check("sw_0c", 1'b1, 64'h0C, 3'b010, 64'hFFFFFFFF80000000, 64'd0, 1'b0, 2);
        req_check("lh_08", 1'b0, 64'h08, 3'b001, 64'd0, 64'hFFFFFFFFFFFF8001, 1'b0, 2);
        req_check("lhu_08", 1'b0, 64'h08, 3'b101, 64'd0, 64'h0000000000008001, 1'b0, 2);
        req_check("lw_0c", 1'b0, 64'h0C, 3'b010, 64'd0, 64'hFFFFFFFF80000000, 1'b0, 2);
        req_check("lwu_0c", 1'b0, 64'h0C, 3'b110, 64'd0, 64'h0000000080000000, 1'b0, 2);
        req_check("ld_08", 1'b0, 64'h08, 3'b011, 64'd0, 64'h8000000000008001, 1'b0, 2);

        // Fault cases
        req_check("lw_mis", 1'b0, 64'h12, 3'b010, 64'd0, 64'd0, 1'b1, 2);
        req_check("lh_mis", 1'b0, 64'h15, 3'b001, 64'd0, 64'd0, 1'b1, 2);
        req_check("sd_oor", 1'b1, 64'h400, 3'b011, 64'hDEADBEEFCAFEF00D, 64'd0, 1'b1, 2);
        req_check("ld_0", 1'b0, 64'h0, 3'b011, 64'd0, 64'd0, 1'b0, 2);
        req_check("ld_oor", 1'b0, 64'h3F8 + 64'h8, 3'b011, 64'd0, 64'd0, 1'b1, 2);
        req_check("st_ill", 1'b1, 64'h18, 3'b100, 64'h1234, 64'd0, 1'b1, 2);
        req_check("ld_ill", 1'b0, 64'h18, 3'b111, 64'd0, 64'd0, 1'b1, 2);
        req_check("ld_18", 1'b0, 64'h18, 3'b011, 64'd0, 64'd0, 1'b0, 2);

        // Backpressure: response held, request pulse ignored
        rsp_ready_drv = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rq_rdy[0]) begin
                ok = 1'b1;
                break;
            end
        end
        chk("bp_ready_seen", {63'd0, ok}, 64'd1);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 64'h10;
        req_size  = 3'b011;
        @(posedge clk);
        #1 req_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_v[0]) begin
                ok = 1'b1;
                break;
            end
        end
        chk("bp_valid_seen", {63'd0, ok}, 64'd1);
        exp_d = 64'h1122FF4455667788;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_valid", {63'd0, rsp_v[0]}, 64'd1);
            chk("bp_rdata", rsp_d[0], exp_d);
            chk("bp_err", {63'd0, rsp_e[0]}, 64'd0);
            chk("bp_req_ready", {63'd0, rq_rdy[0]}, 64'd0);
            if (c == 1) begin
                req_valid = 1'b1;
                req_we    = 1'b1;
                req_addr  = 64'h10;
                req_size  = 3'b011;
                req_wdata = 64'd0;
            end else begin
                req_valid = 1'b0;
            end
        end
        req_valid     = 1'b0;
        rsp_ready_drv = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_valid_drop", {63'd0, rsp_v[0]}, 64'd0);
        req_check("bp_ld_10", 1'b0, 64'h10, 3'b011, 64'd0, 64'h1122FF4455667788, 1'b0, 2);

        // Reset in BUSY on the LATENCY=3 build
        sel = 1;
        ok  = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rq_rdy[1]) begin
                ok = 1'b1;
                break;
            end
        end
        chk("mr_ready_seen", {63'd0, ok}, 64'd1);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 64'h20;
        req_size  = 3'b011;
        req_wdata = 64'h000000000000ABCD;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("mr_busy_valid", {63'd0, rsp_v[1]}, 64'd0);
        rst = 1'b0;
        #1;
        chk("mr_req_ready", {63'd0, rq_rdy[1]}, 64'd0);
        chk("mr_rdata", rsp_d[1], 64'd0);
        chk("mr_err", {63'd0, rsp_e[1]}, 64'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("mr_valid_low", {63'd0, rsp_v[1]}, 64'd0);
        end
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("mr_valid_after", {63'd0, rsp_v[1]}, 64'd0);
        end
        req_check("mr_ld_20", 1'b0, 64'h20, 3'b011, 64'd0, 64'd0, 1'b0, 3);
        sel = 0;
        req_check("mr_l2_cleared", 1'b0, 64'h10, 3'b011, 64'd0, 64'd0, 1'b0, 2);

        // LATENCY=1 build: back-to-back loads with rsp_ready held high
        sel = 2;
        req_check("l1_sd_10", 1'b1, 64'h10, 3'b011, 64'h55, 64'd0, 1'b0, 1);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rq_rdy[2]) begin
                ok = 1'b1;
                break;
            end
        end
        chk("l1_ready_seen", {63'd0, ok}, 64'd1);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 64'h10;
        req_size  = 3'b011;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) begin
                @(negedge clk);
            end
            chk("l1_req_ready", {63'd0, rq_rdy[2]}, {63'd0, (k % 2) == 0});
            chk("l1_rsp_valid", {63'd0, rsp_v[2]}, {63'd0, (k % 2) == 1});
            if ((k % 2) == 1) begin
                chk("l1_rdata", rsp_d[2], 64'h55);
            end
        end
        req_valid = 1'b0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
